mux_scan_ctrl: RTL and testbench
================================

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have parameter: SETTLE_CYC, default 2, select-settle cycles before each sample (legal 0..15).
REQ-002 SHALL have ports:
- clk  input  1  the single clock
- rst  input  1  reset, synchronous and active-high
- start  input  1  scan request pulse
- abort  input  1  cancel the scan in progress
- mux_in  input  1  sampled 16:1 mux output (f_mux_out)
- sel_0, sel_1, sel_2, sel_3  output  1 each  mux select lines
- busy  output  1  scan in progress
- scan_valid  output  1  scan_word holds a complete result
- scan_ack  input  1  consumer accepts scan_word
- scan_word  output  16  captured channel values
REQ-003 SHALL operate on one clock, clk, with a synchronous, active-high reset, rst; all outputs registered.

Function
REQ-004 SHALL map channel index n[3:0] to selects as sel_2=n[3], sel_3=n[2], sel_0=n[1], sel_1=n[0], so n selects din_n.
REQ-005 SHALL implement states IDLE, SETTLE, SAMPLE, HOLD.
REQ-006 IDLE: start=1 and abort=0 at an edge -> SETTLE with n=0, settle counter=SETTLE_CYC, busy=1.
REQ-007 SETTLE: counter decrements each cycle; at 0 -> SAMPLE; SETTLE_CYC=0 -> SAMPLE on the next edge.
REQ-008 SAMPLE (one cycle): scan_word[n] <= mux_in; if n<15, n increments, counter reloads and state -> SETTLE; if n=15 -> HOLD, scan_valid=1, busy=0.
REQ-009 Per channel SHALL take SETTLE_CYC+1 cycles; scan_valid rises exactly 16*(SETTLE_CYC+1) cycles after the start edge (48 at default).
REQ-010 HOLD: scan_valid and scan_word stable until scan_ack=1 at an edge -> IDLE, scan_valid=0 on that edge.
REQ-011 scan_ack outside HOLD SHALL be ignored.
REQ-012 start while busy or in HOLD SHALL be ignored (not queued).
REQ-013 abort=1 in SETTLE or SAMPLE SHALL -> IDLE next edge, busy=0, scan_valid stays 0, scan_word bits already captured retained, selects return to 0.
REQ-014 abort in IDLE or HOLD SHALL be ignored; start and abort together in IDLE -> remain IDLE.
REQ-015 Selects SHALL change only on the edge entering SETTLE for a new channel; 0 in IDLE and HOLD.
REQ-016 Channel counter SHALL not wrap past 15 within a scan.

Reset
REQ-017 rst=1 at an edge SHALL force IDLE, n=0, counter=0, sel_0..sel_3=0, busy=0, scan_valid=0, scan_word=16'h0000.
REQ-018 rst SHALL override start, abort and scan_ack; reset mid-scan discards the partial scan.
REQ-019 First start SHALL be accepted on the first edge after rst deasserts.

Configuration
REQ-020 Macro MUX_SCAN_CONT_EN defined: scan_ack in HOLD -> SETTLE with n=0 (new scan, busy=1 on that edge) instead of IDLE; abort in HOLD -> IDLE, scan_valid=0.
REQ-021 MUX_SCAN_CONT_EN undefined: single-shot behaviour per REQ-010..REQ-014; no other difference.

Verification
REQ-022 Mux inputs = 16'hA5C3, SETTLE_CYC=2, start pulse -> scan_valid at cycle 48, scan_word=16'hA5C3, busy low from cycle 48.
REQ-023 Drive n=5 during scan -> sel_2=0, sel_3=1, sel_0=0, sel_1=1; n=10 -> sel_2=1, sel_3=0, sel_0=1, sel_1=0.
REQ-024 abort at cycle 20 -> IDLE at cycle 21, scan_valid never rises; new start gives full correct scan.
REQ-025 scan_ack withheld 10 cycles after valid, then pulsed -> scan_word stable throughout, scan_valid falls on ack edge; second start during HOLD ignored.
REQ-026 rst at cycle 30 mid-scan -> all outputs zero next edge; SETTLE_CYC=0 build -> valid at cycle 16.
REQ-027 With MUX_SCAN_CONT_EN, ack -> busy=1 same edge, next valid 48 cycles later with updated inputs.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 16:1 analog/digital mux through all channels, waits
// SETTLE_CYC cycles after each select change, samples mux_in, and presents the
// 16-bit result with a valid/ack handshake.
// Optional feature: define MUX_SCAN_CONT_EN for continuous scanning, where an
// ack in HOLD starts the next scan immediately and abort in HOLD returns to idle.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        mux_in,
    output logic        sel_0,
    output logic        sel_1,
    output logic        sel_2,
    output logic        sel_3,
    output logic        busy,
    output logic        scan_valid,
    input  logic        scan_ack,
    output logic [15:0] scan_word
);

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StHold} state_e;

    localparam logic [3:0] SettleLd = 4'(SETTLE_CYC);
    // With no settle time a channel goes straight to its sample cycle, giving
    // one cycle per channel; otherwise SETTLE lasts SETTLE_CYC cycles.
    localparam state_e ChanEntry = (SETTLE_CYC == 0) ? StSample : StSettle;

    state_e     state_q;
    logic [3:0] chan_q;
    logic [3:0] cnt_q;

    // Scan FSM with all outputs registered; selects follow the channel index
    // with the bit order {sel_2, sel_3, sel_0, sel_1} = n.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            chan_q     <= 4'd0;
            cnt_q      <= 4'd0;
            {sel_2, sel_3, sel_0, sel_1} <= 4'd0;
            busy       <= 1'b0;
            scan_valid <= 1'b0;
            scan_word  <= 16'h0000;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start && !abort) begin
                        state_q <= ChanEntry;
                        chan_q  <= 4'd0;
                        cnt_q   <= SettleLd;
                        {sel_2, sel_3, sel_0, sel_1} <= 4'd0;
                        busy    <= 1'b1;
                    end
                end
                StSettle: begin
                    if (abort) begin
                        state_q <= StIdle;
                        {sel_2, sel_3, sel_0, sel_1} <= 4'd0;
                        busy    <= 1'b0;
                    end else if (cnt_q <= 4'd1) begin
                        state_q <= StSample;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StSample: begin
                    if (abort) begin
                        // Bits captured so far are deliberately kept.
                        state_q <= StIdle;
                        {sel_2, sel_3, sel_0, sel_1} <= 4'd0;
                        busy    <= 1'b0;
                    end else begin
                        scan_word[chan_q] <= mux_in;
                        if (chan_q == 4'd15) begin
                            state_q    <= StHold;
                            {sel_2, sel_3, sel_0, sel_1} <= 4'd0;
                            busy       <= 1'b0;
                            scan_valid <= 1'b1;
                        end else begin
                            state_q <= ChanEntry;
                            chan_q  <= chan_q + 4'd1;
                            cnt_q   <= SettleLd;
                            {sel_2, sel_3, sel_0, sel_1} <= chan_q + 4'd1;
                        end
                    end
                end
                StHold: begin
`ifdef MUX_SCAN_CONT_EN
                    if (abort) begin
                        state_q    <= StIdle;
                        scan_valid <= 1'b0;
                    end else if (scan_ack) begin
                        state_q    <= ChanEntry;
                        chan_q     <= 4'd0;
                        cnt_q      <= SettleLd;
                        {sel_2, sel_3, sel_0, sel_1} <= 4'd0;
                        busy       <= 1'b1;
                        scan_valid <= 1'b0;
                    end
`else
                    if (scan_ack) begin
                        state_q    <= StIdle;
                        chan_q     <= 4'd0;
                        scan_valid <= 1'b0;
                    end
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: a behavioural 16:1 mux feeds each DUT from din,
// decoding the channel from the select lines. dut is SETTLE_CYC=2, dut_f is
// SETTLE_CYC=0.
module tb_mux_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, abort, scan_ack, start_f, ack_f;
    logic [15:0] din;
    logic        sel_0, sel_1, sel_2, sel_3, busy, scan_valid;
    logic [15:0] scan_word;
    logic        fsel_0, fsel_1, fsel_2, fsel_3, fbusy, fvalid;
    logic [15:0] fword;
    logic        mux_in, fmux_in;

    always #5 clk = ~clk;

    assign mux_in  = din[{sel_2, sel_3, sel_0, sel_1}];
    assign fmux_in = din[{fsel_2, fsel_3, fsel_0, fsel_1}];

    mux_scan_ctrl #(.SETTLE_CYC(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mux_in(mux_in),
        .sel_0(sel_0), .sel_1(sel_1), .sel_2(sel_2), .sel_3(sel_3),
        .busy(busy), .scan_valid(scan_valid), .scan_ack(scan_ack), .scan_word(scan_word)
    );

    mux_scan_ctrl #(.SETTLE_CYC(0)) dut_f (
        .clk(clk), .rst(rst), .start(start_f), .abort(1'b0), .mux_in(fmux_in),
        .sel_0(fsel_0), .sel_1(fsel_1), .sel_2(fsel_2), .sel_3(fsel_3),
        .busy(fbusy), .scan_valid(fvalid), .scan_ack(ack_f), .scan_word(fword)
    );

    int checks = 0;
    int failures = 0;
    logic [15:0] sb_q[$];

    typedef struct {
        logic [15:0] din;
        logic        poke;      // pulse ack and start mid-scan; both must be ignored
        int          exp_lat;
        logic [15:0] exp_word;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] sels();
        return {sel_2, sel_3, sel_0, sel_1};
    endfunction

    task automatic run_scan(input logic [15:0] d, input logic poke, input int exp_lat,
                            input logic [15:0] exp_word);
        int   k;
        logic got;
        logic [15:0] e;
        din = d;
        @(negedge clk);
        start = 1'b1;
        sb_q.push_back(exp_word);
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        k = 0;
        got = 1'b0;
        while (k < 200 && !got) begin
            @(posedge clk);
            #1;
            k++;
            scan_ack = 1'b0;
            start = 1'b0;
            if (scan_valid) got = 1'b1;
            else if (poke) begin
                if (k == 10) scan_ack = 1'b1;
                if (k == 20) start = 1'b1;
            end
            if (k == 16) chk("sel_ch5", sels(), 4'b0101);
            if (k == 31) chk("sel_ch10", sels(), 4'b1010);
            if (k == exp_lat - 1) chk("busy_before_valid", busy, 1'b1);
        end
        chk("valid_latency", got ? k : -1, exp_lat);
        chk("busy_at_valid", busy, 1'b0);
        chk("sel_in_hold", sels(), 4'b0000);
        e = sb_q.pop_front();
        chk("scan_word", scan_word, e);
    endtask

    task automatic do_ack();
        @(negedge clk);
        scan_ack = 1'b1;
        @(posedge clk);
        #1 scan_ack = 1'b0;
        chk("valid_falls_on_ack", scan_valid, 1'b0);
`ifdef MUX_SCAN_CONT_EN
        chk("busy_on_ack", busy, 1'b1);
`else
        chk("busy_on_ack", busy, 1'b0);
`endif
    endtask

    initial begin
        vec_t vecs[4];
        int   k;
        logic stable, seen;
        logic [15:0] held;

        vecs[0] = '{din: 16'hA5C3, poke: 1'b0, exp_lat: 48, exp_word: 16'hA5C3};
        vecs[1] = '{din: 16'hFFFF, poke: 1'b1, exp_lat: 48, exp_word: 16'hFFFF};
        vecs[2] = '{din: 16'h0000, poke: 1'b0, exp_lat: 48, exp_word: 16'h0000};
        vecs[3] = '{din: 16'h8001, poke: 1'b1, exp_lat: 48, exp_word: 16'h8001};

        rst = 1'b1; start = 1'b0; abort = 1'b0; scan_ack = 1'b0;
        start_f = 1'b0; ack_f = 1'b0; din = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", scan_valid, 1'b0);
        chk("rst_word", scan_word, 16'h0000);
        chk("rst_sel", sels(), 4'b0000);
        chk("rst_f_word", {fbusy, fvalid, fword}, 18'h0);
        @(negedge clk);
        rst = 1'b0;

        // Abort sampled on edge 21 after start: channels 0..5 already captured.
        din = 16'hFFFF;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (k = 1; k <= 21; k++) begin
            @(posedge clk);
            #1 abort = (k == 20);
        end
        chk("abort_busy", busy, 1'b0);
        chk("abort_sel", sels(), 4'b0000);
        chk("abort_word_kept", scan_word, 16'h003F);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1 if (scan_valid || busy) seen = 1'b1;
        end
        chk("abort_no_valid", seen, 1'b0);

        // Table of full scans.
        for (int v = 0; v < 4; v++) begin
            run_scan(vecs[v].din, vecs[v].poke, vecs[v].exp_lat, vecs[v].exp_word);
            do_ack();
        end

        // Hold for 10 cycles without ack; a start in HOLD must be dropped.
        run_scan(16'h5AF0, 1'b0, 48, 16'h5AF0);
        held = 16'h5AF0;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            @(posedge clk);
            #1 if (!scan_valid || busy || scan_word !== held) stable = 1'b1 & 1'b0;
        end
        start = 1'b0;
        chk("hold_stable", stable, 1'b1);
        do_ack();
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 if (busy) seen = 1'b1;
        end
        chk("hold_start_not_queued", seen, 1'b0);

        // Reset at edge 30 of a scan, then start on the first edge after release.
        din = 16'hFFFF;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1 rst = (k == 29);
        end
        chk("midrst_outputs", {busy, scan_valid, sels(), scan_word}, 22'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("first_start_after_rst", busy, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk);
            #1 seen = scan_valid;
        end
        chk("post_rst_valid", seen, 1'b1);
        chk("post_rst_word", scan_word, 16'hFFFF);
        do_ack();

        // SETTLE_CYC=0 instance: one cycle per channel.
        din = 16'h3C69;
        sb_q.push_back(16'h3C69);
        @(negedge clk);
        start_f = 1'b1;
        @(posedge clk);
        #1 start_f = 1'b0;
        k = 0;
        seen = 1'b0;
        while (k < 100 && !seen) begin
            @(posedge clk);
            #1 k++;
            seen = fvalid;
        end
        chk("fast_latency", seen ? k : -1, 16);
        held = sb_q.pop_front();
        chk("fast_word", fword, held);
        @(negedge clk);
        ack_f = 1'b1;
        @(posedge clk);
        #1 ack_f = 1'b0;
        chk("fast_ack", fvalid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
